// File: rtl/display_mux_7seg.sv
// Multiplexed hex 7-segment scanner. Data loads go to a pending register and
// are committed at frame boundaries. Define DISP_LZ_BLANK_EN for leading-zero blanking.
module display_mux_7seg #(
  parameter int unsigned NUM_DIGITOS  = 4,
  parameter int unsigned DIV_REFRESCO = 50000
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic [4*NUM_DIGITOS-1:0] i_Datos,
  input  logic                     i_Cargar,
  input  logic                     i_Habilitar,
  output logic [6:0]               o_Segmentos,
  output logic [NUM_DIGITOS-1:0]   o_Anodos,
  output logic                     o_Pendiente
);

  localparam int unsigned CntW = $clog2(DIV_REFRESCO);
  localparam int unsigned IdxW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
  localparam int unsigned DatW = 4 * NUM_DIGITOS;

  localparam logic [CntW-1:0] CntLast = CntW'(DIV_REFRESCO - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITOS - 1);
  localparam logic [6:0]      SegOff  = 7'b1111111;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0001100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = SegOff;
    endcase
    return seg;
  endfunction

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DatW-1:0]        pend_data_q, pend_data_d;
  logic [DatW-1:0]        active_q, active_d;
  logic                   pend_q, pend_d;
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITOS-1:0] an_q, an_d;

  logic tick;
  logic frame_end;
  logic commit;

  logic [3:0] act_nib [NUM_DIGITOS];

  always_comb begin
    for (int k = 0; k < int'(NUM_DIGITOS); k++) begin
      act_nib[k] = active_q[4*k +: 4];
    end
  end

  // Scan timing, load handshake and atomic commit.
  always_comb begin
    tick      = (cnt_q == CntLast);
    frame_end = tick && (idx_q == IdxLast);
    commit    = frame_end && pend_q;

    cnt_d = tick ? '0 : cnt_q + CntW'(1);

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end

    active_d    = commit ? pend_data_q : active_q;
    pend_data_d = pend_data_q;
    pend_d      = pend_q & ~commit;
    // A load on the commit edge still wins: old pending commits, new data waits.
    if (i_Cargar) begin
      pend_data_d = i_Datos;
      pend_d      = 1'b1;
    end
  end

`ifdef DISP_LZ_BLANK_EN
  logic [NUM_DIGITOS-1:0] lz_blank;
  logic                   lz_run;

  // Blank the contiguous run of zero nibbles from the top; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = int'(NUM_DIGITOS) - 1; k >= 1; k--) begin
      lz_run      = lz_run & (act_nib[k] == 4'h0);
      lz_blank[k] = lz_run;
    end
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = SegOff;
    if (i_Habilitar) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode_hex(act_nib[idx_q]);
`ifdef DISP_LZ_BLANK_EN
      if (lz_blank[idx_q]) begin
        seg_d = SegOff;
      end
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      active_q    <= '0;
      pend_q      <= 1'b0;
      seg_q       <= SegOff;
      an_q        <= '1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign o_Segmentos = seg_q;
  assign o_Anodos    = an_q;
  assign o_Pendiente = pend_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Directed bench for display_mux_7seg with 4 digits and a 4-cycle refresh divider.
// Honours DISP_LZ_BLANK_EN when defined.
module tb_display_mux_7seg;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic [15:0] i_Datos;
  logic        i_Cargar;
  logic        i_Habilitar;
  logic [6:0]  o_Segmentos;
  logic [3:0]  o_Anodos;
  logic        o_Pendiente;

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;

  always #5 clk = ~clk;

  display_mux_7seg #(
    .NUM_DIGITOS (4),
    .DIV_REFRESCO(4)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (i_Reset),
    .i_Datos    (i_Datos),
    .i_Cargar   (i_Cargar),
    .i_Habilitar(i_Habilitar),
    .o_Segmentos(o_Segmentos),
    .o_Anodos   (o_Anodos),
    .o_Pendiente(o_Pendiente)
  );

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] nib;
    logic       all0;
    nib  = v[4*d +: 4];
    all0 = 1'b0;
`ifdef DISP_LZ_BLANK_EN
    if (d > 0) begin
      all0 = 1'b1;
      for (int k = 3; k >= d; k--) begin
        if (v[4*k +: 4] != 4'h0) all0 = 1'b0;
      end
    end
`endif
    return all0 ? 7'b1111111 : SEG_TAB[nib];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  // One edge, then check anode/segment outputs for the digit slot of edge e.
  task automatic step_chk(input logic [15:0] v);
    int         d;
    logic [3:0] an_exp;
    step();
    d      = ((e - 1) / 4) % 4;
    an_exp = 4'b1111;
    an_exp[d] = 1'b0;
    if (i_Habilitar) begin
      chk("anodos", {28'd0, o_Anodos}, {28'd0, an_exp});
      chk("segmentos", {25'd0, o_Segmentos}, {25'd0, exp_seg(v, d)});
    end else begin
      chk("anodos_off", {28'd0, o_Anodos}, 32'hF);
      chk("segmentos_off", {25'd0, o_Segmentos}, 32'h7F);
    end
  endtask

  // Entered with the next edge starting a frame; leaves at the same alignment.
  task automatic load_seq(input logic [15:0] v_new, input logic [15:0] v_old, input int off);
    repeat (off) step_chk(v_old);
    i_Datos  = v_new;
    i_Cargar = 1'b1;
    step_chk(v_old);
    i_Cargar = 1'b0;
    i_Datos  = 16'h0;
    chk("pend_rise", {31'd0, o_Pendiente}, 32'd1);
    while (e % 16 != 0) begin
      step_chk(v_old);
      if (e % 16 == 15) chk("pend_hold", {31'd0, o_Pendiente}, 32'd1);
    end
    chk("pend_fall", {31'd0, o_Pendiente}, 32'd0);
    repeat (16) step_chk(v_new);
  endtask

  initial begin
    i_Reset     = 1'b1;
    i_Habilitar = 1'b1;
    i_Cargar    = 1'b0;
    i_Datos     = 16'h0;
    repeat (3) step();
    chk("rst_anodos", {28'd0, o_Anodos}, 32'hF);
    chk("rst_segmentos", {25'd0, o_Segmentos}, 32'h7F);
    chk("rst_pend", {31'd0, o_Pendiente}, 32'd0);

    i_Reset = 1'b0;
    e       = 0;
    step_chk(16'h0000);
    chk("first_anodos", {28'd0, o_Anodos}, 32'hE);
    chk("first_segmentos", {25'd0, o_Segmentos}, {25'd0, 7'b0000001});
    repeat (31) step_chk(16'h0000);

    load_seq(16'h3210, 16'h0000, 0);
    load_seq(16'h7654, 16'h3210, 2);
    load_seq(16'hBA98, 16'h7654, 5);
    load_seq(16'hFEDC, 16'hBA98, 9);
    load_seq(16'h0000, 16'hFEDC, 0);
    load_seq(16'h1234, 16'h0000, 7);

    // Load arriving on the committing edge.
    repeat (3) step_chk(16'h1234);
    i_Datos  = 16'hAAAA;
    i_Cargar = 1'b1;
    step_chk(16'h1234);
    i_Cargar = 1'b0;
    while (e % 16 != 15) step_chk(16'h1234);
    i_Datos  = 16'h5555;
    i_Cargar = 1'b1;
    step_chk(16'h1234);
    i_Cargar = 1'b0;
    i_Datos  = 16'h0;
    chk("simul_pend", {31'd0, o_Pendiente}, 32'd1);
    repeat (15) step_chk(16'hAAAA);
    chk("simul_pend_hold", {31'd0, o_Pendiente}, 32'd1);
    step_chk(16'hAAAA);
    chk("simul_pend_fall", {31'd0, o_Pendiente}, 32'd0);
    repeat (16) step_chk(16'h5555);

    // Disable mid-frame: scan must keep advancing underneath.
    repeat (5) step_chk(16'h5555);
    i_Habilitar = 1'b0;
    repeat (10) step_chk(16'h5555);
    i_Habilitar = 1'b1;
    repeat (17) step_chk(16'h5555);

    // Reset mid-frame with a load pending.
    repeat (4) step_chk(16'h5555);
    i_Datos  = 16'h9999;
    i_Cargar = 1'b1;
    step_chk(16'h5555);
    i_Cargar = 1'b0;
    i_Datos  = 16'h0;
    chk("pre_rst_pend", {31'd0, o_Pendiente}, 32'd1);
    repeat (3) step_chk(16'h5555);
    i_Reset = 1'b1;
    step();
    chk("mid_rst_anodos", {28'd0, o_Anodos}, 32'hF);
    chk("mid_rst_segmentos", {25'd0, o_Segmentos}, 32'h7F);
    chk("mid_rst_pend", {31'd0, o_Pendiente}, 32'd0);
    i_Reset = 1'b0;
    e       = 0;
    repeat (32) step_chk(16'h0000);
    chk("post_rst_pend", {31'd0, o_Pendiente}, 32'd0);

`ifdef DISP_LZ_BLANK_EN
    load_seq(16'h0070, 16'h0000, 1);
    load_seq(16'h0000, 16'h0070, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux_7seg.md
# display_mux_7seg

Multiplexed multi-digit 7-segment display controller, successor to the single-digit binary-to-7-segment decoder. It takes a packed bus of hexadecimal nibbles and time-multiplexes them onto one shared segment bus, driving one anode line per digit. A refresh prescaler sets the scan rate. A pending/active register pair updates the display atomically at frame boundaries. The block sits between the user datapath and the board's display pins.

## Interface
- NUM_DIGITOS, 4, number of digits scanned; legal 1..8
- DIV_REFRESCO, 50000, clock cycles each digit stays lit; legal ≥2
- i_Clk  in  1  single system clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Datos  in  4*NUM_DIGITOS  packed nibbles; digit k = i_Datos[4k+3:4k]; digit 0 is least significant (rightmost)
- i_Cargar  in  1  load strobe; captures i_Datos into the pending register
- i_Habilitar  in  1  display enable; low blanks all digits without stopping the scan
- o_Segmentos  out  7  {a,b,c,d,e,f,g}; active-low (0 = lit)
- o_Anodos  out  NUM_DIGITOS  one per digit; active-low (0 = digit selected)
- o_Pendiente  out  1  high while captured data has not yet been committed to the display

## Operation
- Prescaler `cnt`, width $clog2(DIV_REFRESCO), counts 0..DIV_REFRESCO-1 and then wraps to 0.
  - `tick` = (cnt == DIV_REFRESCO-1).
- Digit index `idx` increments on tick, modulo NUM_DIGITOS: N-1 → 0.
- Frame boundary = tick while idx == N-1.
- Load handshake:
  - i_Cargar=1 at an edge: pending ← i_Datos and o_Pendiente ← 1. Repeated loads before a commit: the last one wins.
  - At a frame boundary with o_Pendiente=1: active ← pending and o_Pendiente ← 0.
  - i_Cargar on the same edge as a commit: the commit uses the old pending value, the new data is captured, and o_Pendiente stays 1. The new value commits at the next frame boundary.
- Decode (hex, active-low, bits a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Output register, updated every cycle:
  - i_Habilitar=1: o_Anodos = all ones except bit idx = 0; o_Segmentos = decode(active[idx]).
  - i_Habilitar=0: o_Anodos = all ones; o_Segmentos = 7'b1111111.
- Reset, synchronous:
  - cnt=0, idx=0, pending=0, active=0, o_Pendiente=0
  - o_Anodos = all ones, o_Segmentos = 7'b1111111
  - Reset asserted mid-frame or mid-load discards pending data and restarts the scan at digit 0.

## Timing
- Outputs are registered; there is one cycle of latency from an idx change to the anode/segment change.
- First edge after reset is released: o_Anodos=…1110, o_Segmentos=0000001 (digit 0, value 0), provided i_Habilitar=1.
- Each digit is shown for exactly DIV_REFRESCO cycles. Frame period = NUM_DIGITOS*DIV_REFRESCO cycles.
- Commit latency from i_Cargar: between 1 and NUM_DIGITOS*DIV_REFRESCO cycles; new data appears on the first digit-0 output after the commit.
- o_Pendiente rises the cycle after i_Cargar and falls the cycle after the committing boundary.
- i_Habilitar takes effect on outputs after 1 cycle. cnt and idx continue counting while disabled.
- NUM_DIGITOS=1: idx stays 0 and every tick is a frame boundary.

## Configuration
- DISP_LZ_BLANK_EN defined: leading-zero blanking.
  - Scanning from digit N-1 downward, every contiguous zero nibble of `active` is shown as 7'b1111111.
  - Its anode is still driven, so scan timing is unchanged.
  - Digit 0 is never blanked.
  - The leading-zero mask is computed from `active`, so it changes only at commits.
- DISP_LZ_BLANK_EN undefined: every digit is decoded as-is, with no blanking logic.

## Test plan
- Reset/scan (N=4, DIV=4): release reset with i_Habilitar=1 → o_Anodos 1110, 1101, 1011, 0111, repeating every 16 cycles, each state held 4 cycles; o_Segmentos=0000001 throughout.
- Decode sweep: load 0x3210, 0x7654, 0xBA98, 0xFEDC in turn → every digit shows its listed pattern at its anode slot (e.g. digit 2 of 0xFEDC shows E=0110000).
- Atomic commit: load 0x1234 mid-frame while displaying 0x0000 → o_Pendiente=1; no digit changes until the boundary; then digit 0 shows 4=1001100 and o_Pendiente=0.
- Simultaneous load at boundary: pending 0xAAAA, pulse i_Cargar=0x5555 on the boundary edge → frame shows AAAA; o_Pendiente stays 1; the next frame shows 5555.
- Enable/reset mid-operation: i_Habilitar=0 → next cycle all anodes 1 and segments 1111111, while idx continues to advance; i_Reset mid-frame → pending cleared and the scan restarts at digit 0.
- Blanking, with DISP_LZ_BLANK_EN defined: load 0x0070 → digits 3 and 2 show 1111111, digit 1 shows 0001111, digit 0 shows 0000001. Load 0x0000 → only digit 0 is lit.
